pipeline_ctrl: RTL

Pipeline stall/flush sequencer for the 5-stage datapath. It consumes the hazard-detection results (load-use hazard), the resolved branch/jump and halt from the MEM stage, and the cache handshakes (ihit/dhit). It drives the enable and flush controls of the PC and the four pipeline latches, and keeps saturating performance counters. It sits between the hazard unit and the pipeline registers. Forwarding mux selects are not its concern.

---
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush sequencer with saturating performance counters
// Mealy control of the PC and four pipeline latches, prioritised halt > dmem stall > branch > load-use > ifetch stall.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_3,
  input  logic             lw_hazard,
  input  logic             branch_taken_3,
  input  logic             halt_3,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0] state;
  logic [0:0] next_state;
  logic       inc_cycle;
  logic       inc_stall;
  logic       inc_flush;
  logic       inc_bubble;

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    inc_cycle   = 1'b0;
    inc_stall   = 1'b0;
    inc_flush   = 1'b0;
    inc_bubble  = 1'b0;
    next_state  = state;
    // Gating on nRST keeps every latch closed while reset is held, regardless of the stored state.
    if (nRST && (state == RUN)) begin
      inc_cycle = 1'b1;
      if (halt_3) begin
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        next_state  = HALTED;
      end else if (dmem_req_3 && !dhit) begin
        // WB gets a bubble so the stalled MEM instruction does not retire twice.
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
        inc_stall   = 1'b1;
      end else if (branch_taken_3) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        inc_flush   = 1'b1;
      end else if (lw_hazard) begin
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        idex_flush  = 1'b1;
        inc_bubble  = 1'b1;
        inc_stall   = 1'b1;
      end else if (!ihit) begin
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        inc_stall   = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  assign halt = (state == HALTED);

  // Counters hold at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (inc_cycle && (cycle_cnt != '1))   cycle_cnt  <= cycle_cnt + CNT_ONE;
      if (inc_stall && (stall_cnt != '1))   stall_cnt  <= stall_cnt + CNT_ONE;
      if (inc_flush && (flush_cnt != '1))   flush_cnt  <= flush_cnt + CNT_ONE;
      if (inc_bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule
